// File: rtl/fx_bus_pkg.sv
// Shared definitions for the fx register bus: address layout and arbiter states.
package fx_bus_pkg;

  localparam int FX_AW       = 22;
  localparam int FX_DW       = 8;
  localparam int FX_DEV_ID_W = 6;

  // Address layout: device select on top, register offset below.
  localparam int FX_DEV_ID_MSB = 21;
  localparam int FX_DEV_ID_LSB = 16;
  localparam int FX_REG_MSB    = 15;
  localparam int FX_REG_LSB    = 0;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_WR,
    ARB_RD,
    ARB_RWAIT,
    ARB_RACK
  } arb_state_e;

  function automatic logic [FX_DEV_ID_W-1:0] fx_dev_id(input logic [FX_AW-1:0] addr);
    return addr[FX_DEV_ID_MSB:FX_DEV_ID_LSB];
  endfunction

  function automatic logic [FX_REG_MSB-FX_REG_LSB:0] fx_reg(input logic [FX_AW-1:0] addr);
    return addr[FX_REG_MSB:FX_REG_LSB];
  endfunction

endpackage

// File: rtl/fx_bus_arb.sv
// Two-master round-robin arbiter that turns req/ack transactions into
// single-cycle fx_wr/fx_rd strobes and returns registered slave read data.
module fx_bus_arb
  import fx_bus_pkg::*;
#(
  parameter int AW = FX_AW,
  parameter int DW = FX_DW
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          fx_wr,
  output logic [AW-1:0] fx_waddr,
  output logic [DW-1:0] fx_data,
  output logic          fx_rd,
  output logic [AW-1:0] fx_raddr,
  input  logic [DW-1:0] fx_q,
  output logic          busy,
  output logic          gnt
);

  arb_state_e    state, state_nxt;
  logic          last_gnt, last_gnt_nxt;
  logic          pick;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  logic          gnt_nxt, busy_nxt;
  logic          m0_ack_nxt, m1_ack_nxt;
  logic [DW-1:0] m0_rdata_nxt, m1_rdata_nxt;
  logic          fx_wr_nxt, fx_rd_nxt;
  logic [AW-1:0] fx_waddr_nxt, fx_raddr_nxt;
  logic [DW-1:0] fx_data_nxt;

  // On a tie the master that did not win last time goes next.
  always_comb begin
    pick = (m0_req && m1_req) ? ~last_gnt : m1_req;
  end

  assign sel_we    = pick ? m1_we    : m0_we;
  assign sel_addr  = pick ? m1_addr  : m0_addr;
  assign sel_wdata = pick ? m1_wdata : m0_wdata;

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    gnt_nxt      = gnt;
    m0_ack_nxt   = 1'b0;
    m1_ack_nxt   = 1'b0;
    m0_rdata_nxt = m0_rdata;
    m1_rdata_nxt = m1_rdata;
    fx_wr_nxt    = 1'b0;
    fx_rd_nxt    = 1'b0;
    fx_waddr_nxt = fx_waddr;
    fx_data_nxt  = fx_data;
    fx_raddr_nxt = fx_raddr;

    unique case (state)
      ARB_IDLE: begin
        if (m0_req || m1_req) begin
          gnt_nxt      = pick;
          last_gnt_nxt = pick;
          if (sel_we) begin
            state_nxt    = ARB_WR;
            fx_wr_nxt    = 1'b1;
            fx_waddr_nxt = sel_addr;
            fx_data_nxt  = sel_wdata;
            m0_ack_nxt   = ~pick;
            m1_ack_nxt   = pick;
          end else begin
            state_nxt    = ARB_RD;
            fx_rd_nxt    = 1'b1;
            fx_raddr_nxt = sel_addr;
          end
        end
      end
      ARB_WR:    state_nxt = ARB_IDLE;
      ARB_RD:    state_nxt = ARB_RWAIT;
      // fx_q is valid here, one cycle after the read strobe.
      ARB_RWAIT: begin
        state_nxt = ARB_RACK;
        if (gnt) begin
          m1_rdata_nxt = fx_q;
          m1_ack_nxt   = 1'b1;
        end else begin
          m0_rdata_nxt = fx_q;
          m0_ack_nxt   = 1'b1;
        end
      end
      ARB_RACK:  state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase

    busy_nxt = (state_nxt != ARB_IDLE);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      last_gnt <= 1'b1;
      gnt      <= 1'b0;
      busy     <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      fx_wr    <= 1'b0;
      fx_rd    <= 1'b0;
      fx_waddr <= '0;
      fx_data  <= '0;
      fx_raddr <= '0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      gnt      <= gnt_nxt;
      busy     <= busy_nxt;
      m0_ack   <= m0_ack_nxt;
      m1_ack   <= m1_ack_nxt;
      m0_rdata <= m0_rdata_nxt;
      m1_rdata <= m1_rdata_nxt;
      fx_wr    <= fx_wr_nxt;
      fx_rd    <= fx_rd_nxt;
      fx_waddr <= fx_waddr_nxt;
      fx_data  <= fx_data_nxt;
      fx_raddr <= fx_raddr_nxt;
    end
  end

endmodule
